eth_stream_arbiter: RTL and testbench
=====================================

Name: eth_stream_arbiter

Overview:
- Downstream consumer of the per-channel AXI-snoop submodules (AW, W, B, AR, R capture stages).
- Each submodule presents a beat stream using valid / in_progress / last / data / 6-bit transaction length.
- This block round-robin arbitrates among them and serialises one whole transaction at a time onto a single AXI-Stream master toward the Ethernet packetiser.
- Keeps a sticky protocol-error register and a transmitted-transaction counter.

Parameters:
- DATA_WIDTH, 128, width of each submodule data bus and of m_axis_tdata.
- NUM_SRC, 5, number of submodule inputs (1..16).
- IDX_WIDTH, 4, width of the source index; must satisfy 2^IDX_WIDTH >= NUM_SRC.

Ports:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- src_valid  input  NUM_SRC  per-source "has beat available".
- src_in_progress  input  NUM_SRC  per-source "currently streaming".
- src_last  input  NUM_SRC  per-source final-beat flag.
- src_len  input  6*NUM_SRC  per-source transaction length in beats; slice i is [6i+5:6i]; value 0 means 64.
- src_data  input  DATA_WIDTH*NUM_SRC  per-source beat data; slice i is [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- src_ready  output  NUM_SRC  per-source ready; one-hot or zero.
- m_axis_tdata  output  DATA_WIDTH  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tlast  output  1  final beat of a transaction.
- m_axis_tready  input  1  stream ready.
- grant_idx  output  IDX_WIDTH  index of the current or last granted source.
- err_flags  output  2  sticky: bit0 = length/last mismatch, bit1 = in_progress seen on a non-granted source while another is granted.
- txn_count  output  32  completed transactions; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; src_ready = 0; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0.
  - grant_idx = NUM_SRC-1, so source 0 has first priority.
  - err_flags = 0; txn_count = 0; beat counter = 0.
- Reset mid-transaction aborts the transaction immediately. No partial tlast is emitted; the source is not informed.
- States: IDLE, HDR (only with the optional feature), STREAM.
- IDLE:
  - All outputs quiet.
  - If any src_valid is set, pick the first set bit scanning from grant_idx+1 upward, wrapping at NUM_SRC.
  - Register that index into grant_idx and latch len_q = src_len slice (0 -> 64).
  - Clear the beat counter and go to STREAM (or HDR).
  - Arbitration costs exactly one idle cycle between transactions.
- STREAM, with g = grant_idx:
  - src_ready[g] = m_axis_tready; all other src_ready bits = 0.
  - m_axis_tvalid = src_valid[g]; m_axis_tdata = src_data[g] (combinational mux, zero latency).
  - m_axis_tlast = (beat_cnt == len_q-1) && m_axis_tvalid.
- Beat handshake is m_axis_tvalid && m_axis_tready. On each beat:
  - beat_cnt increments.
  - If src_last[g] != m_axis_tlast, set err_flags[0].
- On the beat with tlast: txn_count += 1 and return to IDLE. The transaction always ends on the latched length; src_last is only checked.
- In any non-IDLE state: if src_in_progress[j] is high for any j != g, set err_flags[1].
- Backpressure: while tready = 0, src_ready[g] = 0 and the source holds its beat. The block holds no data and needs no skid buffer.
- If a source drops src_valid mid-transaction, m_axis_tvalid drops with it. The grant is held; there is no timeout.
- err_flags clear only on reset.

Optional Feature:
- Macro: ETH_ARB_HEADER_EN.
- Defined:
  - IDLE goes to HDR after the grant.
  - HDR drives m_axis_tvalid = 1, m_axis_tlast = 0, src_ready = 0.
  - HDR tdata: [5:0] = raw src_len, [7:6] = 0, [8+IDX_WIDTH-1:8] = grant_idx, rest = 0.
  - HDR advances to STREAM on tready.
  - Each transaction is len+1 beats on the stream.
- Undefined: HDR does not exist; IDLE goes directly to STREAM.

Test Plan:
- Single source 0: len = 3, valid held, tready = 1 → 3 beats with data D0..D2, tlast on beat 3, txn_count = 1, grant_idx = 0, err_flags = 0.
- Sources 1 and 3 both valid, len = 2 each, after reset → order is 1 then 3, then 1 again if it is still valid; one idle cycle between transactions.
- tready toggles 1,0,0,1,1 on a len = 3 transaction → src_ready mirrors tready; exactly 3 beats transfer; tdata is stable while stalled.
- src_len = 0 → 64 beats with tlast only on beat 64. Separately, src_last asserted on beat 2 of a len = 4 transaction → 4 beats still sent and err_flags[0] = 1.
- Source 2 granted, source 4 raises in_progress → err_flags[1] = 1. Then reset asserted on beat 2 → all outputs 0 asynchronously, err_flags = 0, txn_count = 0.
- With ETH_ARB_HEADER_EN, source 2, len = 5 → header tdata = 0x0205, then 5 data beats, tlast on beat 6 of the stream.

Source files
------------

// File: rtl/eth_stream_arbiter.sv
// Round-robin arbiter serialising whole AXI-snoop transactions onto one AXI-Stream.
// Define ETH_ARB_HEADER_EN to prefix each transaction with a header beat.
module eth_stream_arbiter #(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_SRC    = 5,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC-1:0]            src_in_progress,
   input  logic [NUM_SRC-1:0]            src_last,
   input  logic [6*NUM_SRC-1:0]          src_len,
   input  logic [DATA_WIDTH*NUM_SRC-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic [IDX_WIDTH-1:0]          grant_idx,
   output logic [1:0]                    err_flags,
   output logic [31:0]                   txn_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HDR    = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [IDX_WIDTH-1:0]  pick_idx;
   logic                  pick_any;
   logic [6:0]            pick_len, len_q, beat_cnt;
   logic                  g_valid, g_last, other_busy;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  fire;

   // first valid source after the last grant, wrapping at NUM_SRC
   always_comb begin
      int t;
      t        = 0;
      pick_any = 1'b0;
      pick_idx = grant_idx;
      pick_len = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         t = int'(grant_idx) + k;
         if (t >= NUM_SRC) t = t - NUM_SRC;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!pick_any && i == t && src_valid[i]) begin
               pick_any = 1'b1;
               pick_idx = IDX_WIDTH'(i);
               pick_len = {src_len[6*i +: 6] == 6'd0, src_len[6*i +: 6]};
            end
         end
      end
   end

   always_comb begin
      g_valid    = 1'b0;
      g_last     = 1'b0;
      g_data     = '0;
      other_busy = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_idx == IDX_WIDTH'(i)) begin
            g_valid = src_valid[i];
            g_last  = src_last[i];
            g_data  = src_data[DATA_WIDTH*i +: DATA_WIDTH];
         end else if (src_in_progress[i]) begin
            other_busy = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      src_ready     = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      fire          = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
`ifdef ETH_ARB_HEADER_EN
               state_nxt = HDR;
`else
               state_nxt = STREAM;
`endif
            end
         end
`ifdef ETH_ARB_HEADER_EN
         HDR: begin
            m_axis_tvalid              = 1'b1;
            m_axis_tdata[5:0]          = len_q[5:0];
            m_axis_tdata[8+:IDX_WIDTH] = grant_idx;
            if (m_axis_tready) state_nxt = STREAM;
         end
`endif
         STREAM: begin
            m_axis_tvalid = g_valid;
            m_axis_tdata  = g_data;
            m_axis_tlast  = g_valid && (beat_cnt == len_q - 7'd1);
            for (int i = 0; i < NUM_SRC; i++)
               src_ready[i] = m_axis_tready && (grant_idx == IDX_WIDTH'(i));
            fire = g_valid && m_axis_tready;
            if (fire && m_axis_tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_idx <= IDX_WIDTH'(NUM_SRC - 1);
         len_q     <= '0;
         beat_cnt  <= '0;
         err_flags <= '0;
         txn_count <= '0;
      end else begin
         if (state == IDLE && pick_any) begin
            grant_idx <= pick_idx;
            len_q     <= pick_len;
            beat_cnt  <= '0;
         end
         if (fire) begin
            beat_cnt <= beat_cnt + 7'd1;
            if (g_last != m_axis_tlast) err_flags[0] <= 1'b1;
            if (m_axis_tlast) txn_count <= txn_count + 32'd1;
         end
         if (state != IDLE && other_busy) err_flags[1] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Bench for eth_stream_arbiter: vector table, corner sequences and a
// randomized run against a transaction-level round-robin model.
module tb_eth_stream_arbiter;
   localparam int DW = 128;
   localparam int NS = 5;
   localparam int IW = 4;
`ifdef ETH_ARB_HEADER_EN
   localparam int HDR_EN = 1;
`else
   localparam int HDR_EN = 0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [NS-1:0]   src_valid, src_in_progress, src_last, src_ready;
   logic [6*NS-1:0] src_len;
   logic [DW*NS-1:0] src_data;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [IW-1:0]   grant_idx;
   logic [1:0]      err_flags;
   logic [31:0]     txn_count;

   int checks = 0;
   int errors = 0;

   eth_stream_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .IDX_WIDTH(IW)) dut (
      .clk(clk), .reset(reset),
      .src_valid(src_valid), .src_in_progress(src_in_progress),
      .src_last(src_last), .src_len(src_len), .src_data(src_data),
      .src_ready(src_ready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready), .grant_idx(grant_idx),
      .err_flags(err_flags), .txn_count(txn_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         src;
      logic [5:0] len;
      logic [7:0] rdy;
      int         last_at;
      int         beats;
      int         txn;
      logic [1:0] err;
   } row_t;

   row_t       rows[6];
   int         ntx[NS];
   logic [5:0] lens[NS][4];

   function automatic logic [127:0] mk(int s, int n, int b);
      return {32'(s), 32'(n), 32'(b), 32'hCAFEF00D};
   endfunction

   function automatic logic [127:0] hdr(int s, logic [5:0] l);
      return (128'(s) << 8) | 128'(l);
   endfunction

   function automatic int eff(logic [5:0] l);
      return (l == 6'd0) ? 64 : int'(l);
   endfunction

   task automatic chk(input string name, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic clear_inputs();
      src_valid       = '0;
      src_in_progress = '0;
      src_last        = '0;
      src_len         = '0;
      src_data        = '0;
      m_axis_tready   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tvalid"}, m_axis_tvalid, 0);
      chk({tag, "_tlast"}, m_axis_tlast, 0);
      chk({tag, "_tdata"}, m_axis_tdata, 0);
      chk({tag, "_ready"}, src_ready, 0);
      chk({tag, "_grant"}, grant_idx, NS - 1);
      chk({tag, "_err"}, err_flags, 0);
      chk({tag, "_txn"}, txn_count, 0);
   endtask

   task automatic run_row(input row_t r, input int id);
      int k, sb, tot;
      logic [127:0] exp;
      string tag;
      tag = $sformatf("row%0d", id);
      k   = 0;
      sb  = 0;
      tot = r.beats + HDR_EN;
      for (int cyc = 0; cyc < 400 && k < tot; cyc++) begin
         @(negedge clk);
         src_valid = NS'(1 << r.src);
         src_len[6*r.src +: 6] = r.len;
         src_data[DW*r.src +: DW] = mk(r.src, 0, sb);
         src_last = (sb == r.last_at) ? NS'(1 << r.src) : '0;
         m_axis_tready = r.rdy[cyc % 8];
         #1;
         if (m_axis_tvalid) begin
            exp = (HDR_EN == 1 && k == 0) ? hdr(r.src, r.len)
                                           : mk(r.src, 0, k - HDR_EN);
            chk({tag, "_data"}, m_axis_tdata, exp);
            chk({tag, "_last"}, m_axis_tlast, k == tot - 1);
            chk({tag, "_ready"}, src_ready,
                ((HDR_EN == 1 && k == 0) || !m_axis_tready) ? 0 : (1 << r.src));
            if (m_axis_tready) begin
               k++;
               if (src_ready[r.src]) sb++;
            end
         end
      end
      chk({tag, "_beats"}, k, tot);
      @(negedge clk);
      clear_inputs();
      #1;
      chk({tag, "_idle"}, m_axis_tvalid, 0);
      chk({tag, "_txn"}, txn_count, r.txn);
      chk({tag, "_grant"}, grant_idx, r.src);
      chk({tag, "_err"}, err_flags, r.err);
   endtask

   task automatic run_engine(input bit bubble, input int rdy_pct,
                             output int total, output int cycles);
      int ord_s[$];
      int ord_n[$];
      int left[NS];
      int n[NS], b[NS];
      int lst, f, s, oi, eb, es, en, tot, cyc;
      logic [127:0] exp;
      left = ntx;
      lst  = NS - 1;
      for (int guard = 0; guard < 64; guard++) begin
         f = -1;
         for (int k = 1; k <= NS; k++) begin
            s = (lst + k) % NS;
            if (f < 0 && left[s] > 0) f = s;
         end
         if (f < 0) break;
         ord_s.push_back(f);
         ord_n.push_back(ntx[f] - left[f]);
         left[f]--;
         lst = f;
      end
      total = ord_s.size();
      for (int i = 0; i < NS; i++) begin
         n[i] = 0;
         b[i] = 0;
      end
      oi = 0;
      eb = 0;
      for (cyc = 0; oi < total && cyc < 20000; cyc++) begin
         @(negedge clk);
         m_axis_tready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
         for (int i = 0; i < NS; i++) begin
            if (n[i] < ntx[i]) begin
               src_valid[i] = (b[i] == 0 || !bubble) ? 1'b1
                              : ($urandom_range(0, 3) != 0);
               src_len[6*i +: 6] = lens[i][n[i]];
               src_data[DW*i +: DW] = mk(i, n[i], b[i]);
               src_last[i] = (b[i] == eff(lens[i][n[i]]) - 1);
               src_in_progress[i] = (b[i] > 0);
            end else begin
               src_valid[i] = 1'b0;
               src_last[i] = 1'b0;
               src_in_progress[i] = 1'b0;
            end
         end
         #1;
         es  = ord_s[oi];
         en  = ord_n[oi];
         tot = eff(lens[es][en]) + HDR_EN;
         if (m_axis_tvalid && m_axis_tready) begin
            exp = (HDR_EN == 1 && eb == 0) ? hdr(es, lens[es][en])
                                            : mk(es, en, eb - HDR_EN);
            chk("rnd_data", m_axis_tdata, exp);
            chk("rnd_last", m_axis_tlast, eb == tot - 1);
            chk("rnd_ready", src_ready,
                (HDR_EN == 1 && eb == 0) ? 0 : (1 << es));
            eb++;
            if (eb == tot) begin
               oi++;
               eb = 0;
            end
         end
         for (int i = 0; i < NS; i++) begin
            if (src_valid[i] && src_ready[i]) begin
               b[i]++;
               if (b[i] == eff(lens[i][n[i]])) begin
                  b[i] = 0;
                  n[i]++;
               end
            end
         end
      end
      cycles = cyc;
      chk("rnd_done", oi, total);
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      int tot, cyc, sb;
      reset = 1'b1;
      clear_inputs();
      rows[0] = '{0, 6'd3, 8'hFF, 2, 3, 1, 2'b00};
      rows[1] = '{3, 6'd3, 8'hF3, 2, 3, 2, 2'b00};
      rows[2] = '{4, 6'd0, 8'hFF, 63, 64, 3, 2'b00};
      rows[3] = '{2, 6'd5, 8'hFF, 4, 5, 4, 2'b00};
      rows[4] = '{1, 6'd1, 8'hAA, 0, 1, 5, 2'b00};
      rows[5] = '{0, 6'd4, 8'hFF, 1, 4, 6, 2'b01};

      #2;
      chk_reset("rst");
      @(negedge clk);
      reset = 1'b0;

      for (int r = 0; r < 6; r++) run_row(rows[r], r);

      // two contenders: 1, 3, then 1 again, one idle cycle apart
      do_reset();
      ntx = '{0, 2, 0, 1, 0};
      for (int i = 0; i < NS; i++)
         for (int j = 0; j < 4; j++) lens[i][j] = 6'd2;
      run_engine(1'b0, 100, tot, cyc);
      chk("rr_cycles", cyc, 3 * (3 + HDR_EN));
      chk("rr_txn", txn_count, 3);
      chk("rr_grant", grant_idx, 1);
      chk("rr_err", err_flags, 0);

      // foreign in_progress, then reset in the middle of beat 2
      do_reset();
      src_valid = 5'b00100;
      src_in_progress = 5'b10000;
      src_len[12 +: 6] = 6'd4;
      src_data[2*DW +: DW] = mk(2, 0, 0);
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      chk("inprog_idle", err_flags, 0);
      sb = 0;
      for (int c = 0; c < 10 && sb < 1; c++) begin
         @(negedge clk);
         src_data[2*DW +: DW] = mk(2, 0, sb);
         #1;
         if (src_ready[2]) sb++;
      end
      chk("inprog_beat", sb, 1);
      @(negedge clk);
      src_data[2*DW +: DW] = mk(2, 0, 1);
      #1;
      chk("inprog_err", err_flags, 2'b10);
      chk("beat2_valid", m_axis_tvalid, 1);
      chk("beat2_data", m_axis_tdata, mk(2, 0, 1));
      #1;
      reset = 1'b1;
      #1;
      chk_reset("midrst");
      @(negedge clk);
      reset = 1'b0;

      for (int round = 0; round < 4; round++) begin
         do_reset();
         for (int i = 0; i < NS; i++) begin
            ntx[i] = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++)
               lens[i][j] = ($urandom_range(0, 15) == 0) ? 6'd0
                            : 6'($urandom_range(1, 8));
         end
         run_engine(1'b1, 70, tot, cyc);
         chk("rnd_txn", txn_count, tot);
         chk("rnd_err", err_flags, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
